// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS-I Harvard core.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_SLTI    = 6'd10;
    localparam logic [5:0] OP_SLTIU   = 6'd11;
    localparam logic [5:0] OP_ANDI    = 6'd12;
    localparam logic [5:0] OP_ORI     = 6'd13;
    localparam logic [5:0] OP_XORI    = 6'd14;
    localparam logic [5:0] OP_LUI     = 6'd15;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_SLLV = 6'd4;
    localparam logic [5:0] FN_SRLV = 6'd6;
    localparam logic [5:0] FN_SRAV = 6'd7;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_JALR = 6'd9;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    localparam logic [4:0] RT_BLTZ   = 5'd0;
    localparam logic [4:0] RT_BGEZ   = 5'd1;
    localparam logic [4:0] RT_BLTZAL = 5'd16;
    localparam logic [4:0] RT_BGEZAL = 5'd17;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_LINK
    } alu_op_e;

endpackage

// File: rtl/mips_cpu_harvard_core_regfile.sv
// 32x32 GPR file: two combinational read ports, one posedge write port, $0 reads as zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [XLEN-1:0]   rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_b,
    output logic [XLEN-1:0]   reg_v0
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
    assign reg_v0  = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I integer core with separate instruction and data ports and a branch delay slot.
module mips_cpu_harvard_core #(
    parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = mips_pkg::HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    import mips_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d, npc_q, npc_d;
    logic            halted, commit;

    logic [5:0]        op, funct;
    logic [REG_AW-1:0] rs, rt, rd, shamt, shift_amt;
    logic [15:0]       imm16;
    logic [XLEN-1:0]   imm_s, imm_z, seq_pc, link_addr, branch_target, jump_target;
    logic [XLEN-1:0]   rs_val, rt_val, op_b, alu_res, wb_data, br_target;
    logic [REG_AW-1:0] wr_addr;
    logic              wr_en, shift_var, br_taken, is_load, is_store;
    alu_op_e           alu_op;

    assign halted = (pc_q == HALT_ADDR);
    assign active = reset & ~halted;
    assign commit = clk_enable & active;

    assign op     = instr_readdata[31:26];
    assign rs     = instr_readdata[25:21];
    assign rt     = instr_readdata[20:16];
    assign rd     = instr_readdata[15:11];
    assign shamt  = instr_readdata[10:6];
    assign funct  = instr_readdata[5:0];
    assign imm16  = instr_readdata[15:0];
    assign imm_s  = {{16{imm16[15]}}, imm16};
    assign imm_z  = {16'h0000, imm16};

    assign seq_pc        = pc_q + 32'd4;
    assign link_addr     = pc_q + 32'd8;
    assign branch_target = seq_pc + {imm_s[29:0], 2'b00};
    assign jump_target   = {seq_pc[31:28], instr_readdata[25:0], 2'b00};

    mips_regfile u_regfile (
        .clk     (clk),
        .rst_n   (reset),
        .we      (wr_en & commit),
        .waddr   (wr_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rs_val),
        .raddr_b (rt),
        .rdata_b (rt_val),
        .reg_v0  (register_v0)
    );

    // Decode: unknown opcodes/functs fall through the defaults and behave as NOP.
    always_comb begin
        alu_op    = ALU_ADD;
        op_b      = rt_val;
        shift_var = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = rd;
        br_taken  = 1'b0;
        br_target = branch_target;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                wr_en = 1'b1;
                case (funct)
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    FN_JR:   begin wr_en = 1'b0; br_taken = 1'b1; br_target = rs_val; end
                    FN_JALR: begin alu_op = ALU_LINK; br_taken = 1'b1; br_target = rs_val; end
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    default: wr_en = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                // Linking forms write $31 whether or not the branch is taken.
                alu_op  = ALU_LINK;
                wr_addr = 5'd31;
                case (rt)
                    RT_BLTZ:   br_taken = rs_val[31];
                    RT_BGEZ:   br_taken = ~rs_val[31];
                    RT_BLTZAL: begin br_taken = rs_val[31];  wr_en = 1'b1; end
                    RT_BGEZAL: begin br_taken = ~rs_val[31]; wr_en = 1'b1; end
                    default:   br_taken = 1'b0;
                endcase
            end
            OP_J:    begin br_taken = 1'b1; br_target = jump_target; end
            OP_JAL:  begin
                br_taken  = 1'b1;
                br_target = jump_target;
                alu_op    = ALU_LINK;
                wr_en     = 1'b1;
                wr_addr   = 5'd31;
            end
            OP_BEQ:  br_taken = (rs_val == rt_val);
            OP_BNE:  br_taken = (rs_val != rt_val);
            OP_BLEZ: br_taken = rs_val[31] | (rs_val == '0);
            OP_BGTZ: br_taken = ~rs_val[31] & (rs_val != '0);
            OP_ADDIU: begin op_b = imm_s; wr_en = 1'b1; wr_addr = rt; end
            OP_SLTI:  begin alu_op = ALU_SLT;  op_b = imm_s; wr_en = 1'b1; wr_addr = rt; end
            OP_SLTIU: begin alu_op = ALU_SLTU; op_b = imm_s; wr_en = 1'b1; wr_addr = rt; end
            OP_ANDI:  begin alu_op = ALU_AND;  op_b = imm_z; wr_en = 1'b1; wr_addr = rt; end
            OP_ORI:   begin alu_op = ALU_OR;   op_b = imm_z; wr_en = 1'b1; wr_addr = rt; end
            OP_XORI:  begin alu_op = ALU_XOR;  op_b = imm_z; wr_en = 1'b1; wr_addr = rt; end
            OP_LUI:   begin alu_op = ALU_LUI;  wr_en = 1'b1; wr_addr = rt; end
            OP_LW:    begin is_load = 1'b1; wr_en = 1'b1; wr_addr = rt; end
            OP_SW:    is_store = 1'b1;
            default:  wr_en = 1'b0;
        endcase
    end

    assign shift_amt = shift_var ? rs_val[4:0] : shamt;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_val + op_b;
            ALU_SUB:  alu_res = rs_val - op_b;
            ALU_AND:  alu_res = rs_val & op_b;
            ALU_OR:   alu_res = rs_val | op_b;
            ALU_XOR:  alu_res = rs_val ^ op_b;
            ALU_NOR:  alu_res = ~(rs_val | op_b);
            ALU_SLT:  alu_res = {31'd0, $signed(rs_val) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'd0, rs_val < op_b};
            ALU_SLL:  alu_res = rt_val << shift_amt;
            ALU_SRL:  alu_res = rt_val >> shift_amt;
            ALU_SRA:  alu_res = 32'($signed(rt_val) >>> shift_amt);
            ALU_LUI:  alu_res = {imm16, 16'h0000};
            ALU_LINK: alu_res = link_addr;
            default:  alu_res = '0;
        endcase
    end

    assign wb_data        = is_load ? data_readdata : alu_res;
    assign data_address   = rs_val + imm_s;
    assign data_writedata = rt_val;
    assign data_read      = is_load & commit;
    assign data_write     = is_store & commit;
    assign instr_address  = pc_q;

    // The delay slot comes from npc_q; a taken branch only redirects the fetch after it.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (commit) begin
            pc_d  = npc_q;
            npc_d = br_taken ? br_target : npc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            npc_q <= RESET_VECTOR + 32'd4;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Directed program bench for mips_cpu_harvard_core with a small instruction ROM and data RAM.
module tb_mips_cpu_harvard_core;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk, reset, active, clk_enable, data_write, data_read;
    logic [31:0] register_v0, instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;

    logic [15:0][31:0] cur_prog;
    logic [15:0][31:0] p;
    logic [31:0]       dmem [16];
    logic [31:0]       ioff;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string             name;
        logic [15:0][31:0] prog;
        logic [31:0]       exp_v0;
        int                exp_cycles;
        int                exp_writes;
        logic [31:0]       exp_wd;
    } vec_t;
    vec_t vecs[12];

    mips_cpu_harvard_core dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ioff           = instr_address - RV;
        instr_readdata = (ioff < 32'd64) ? cur_prog[ioff[5:2]] : 32'h0;
    end

    assign data_readdata = dmem[data_address[5:2]];
    always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish before 400us");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input logic [31:0] v0, input int cyc,
                           input int wr, input logic [31:0] wd);
        vecs[i].name       = nm;
        vecs[i].prog       = p;
        vecs[i].exp_v0     = v0;
        vecs[i].exp_cycles = cyc;
        vecs[i].exp_writes = wr;
        vecs[i].exp_wd     = wd;
    endtask

    // Hold reset across a falling edge, release on the next one so the first posedge runs RV.
    task automatic do_reset();
        clk_enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic run_to_halt(output int cycles, output int writes, output logic [31:0] wd);
        cycles = 0;
        writes = 0;
        wd     = 32'h0;
        while (active === 1'b1 && cycles < 200) begin
            if (data_write === 1'b1) begin
                writes++;
                wd = data_writedata;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] jr0, nop0, inc2, wd;
        logic [31:0] exp_fetch [6];
        int          cyc, wr;

        reset      = 1'b1;
        clk_enable = 1'b1;
        cur_prog   = '0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;

        jr0  = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'd8);
        nop0 = enc_i(6'd9, 5'd0, 5'd0, 16'h0000);
        inc2 = enc_i(6'd9, 5'd2, 5'd2, 16'h0001);

        p = '0; p[0] = enc_i(6'd1, 5'd1, 5'd1, 16'd2); p[1] = inc2; p[2] = inc2; p[3] = inc2;
        p[4] = jr0; p[5] = nop0;
        set_vec(0, "bgez_taken", 32'd2, 5, 0, 32'h0);

        p[0] = enc_i(6'd1, 5'd1, 5'd0, 16'd2);
        set_vec(1, "bltz_not_taken", 32'd3, 6, 0, 32'h0);

        p = '0; p[0] = enc_i(6'd15, 5'd0, 5'd3, 16'h1234); p[1] = enc_i(6'd13, 5'd3, 5'd3, 16'h5678);
        p[2] = enc_i(6'd43, 5'd0, 5'd3, 16'h0); p[3] = enc_i(6'd35, 5'd0, 5'd2, 16'h0);
        p[4] = jr0; p[5] = nop0;
        set_vec(2, "lw_sw_roundtrip", 32'h1234_5678, 6, 1, 32'h1234_5678);

        p = '0; p[0] = {6'd3, 26'h3F0_0008}; p[1] = 32'h0;
        p[8] = enc_i(6'd9, 5'd0, 5'd0, 16'd5); p[9] = enc_r(5'd31, 5'd0, 5'd2, 5'd0, 6'd33);
        p[10] = jr0; p[11] = nop0;
        set_vec(3, "jal_link_r0", 32'hBFC0_0008, 6, 0, 32'h0);

        p = '0; p[0] = enc_i(6'd9, 5'd0, 5'd1, 16'hFFFD); p[1] = enc_r(5'd0, 5'd1, 5'd2, 5'd1, 6'd3);
        p[2] = jr0; p[3] = nop0;
        set_vec(4, "sra_negative", 32'hFFFF_FFFE, 4, 0, 32'h0);

        p[0] = enc_i(6'd9, 5'd0, 5'd1, 16'hFFFF); p[1] = enc_i(6'd10, 5'd1, 5'd2, 16'h0000);
        set_vec(5, "slti_signed", 32'd1, 4, 0, 32'h0);

        p[0] = enc_i(6'd15, 5'd0, 5'd1, 16'h0001); p[1] = enc_i(6'd11, 5'd1, 5'd2, 16'h8000);
        set_vec(6, "sltiu_sext_imm", 32'd1, 4, 0, 32'h0);

        p[0] = enc_i(6'd13, 5'd0, 5'd1, 16'h00F0); p[1] = enc_r(5'd1, 5'd0, 5'd2, 5'd0, 6'd39);
        set_vec(7, "ori_nor", 32'hFFFF_FF0F, 4, 0, 32'h0);

        p[0] = enc_i(6'd9, 5'd0, 5'd1, 16'hFFFF); p[1] = enc_i(6'd14, 5'd1, 5'd2, 16'h8000);
        set_vec(8, "xori_zext", 32'hFFFF_7FFF, 4, 0, 32'h0);

        p[0] = enc_i(6'd9, 5'd0, 5'd1, 16'h0001); p[1] = enc_r(5'd0, 5'd1, 5'd2, 5'd0, 6'd35);
        set_vec(9, "subu_wrap", 32'hFFFF_FFFF, 4, 0, 32'h0);

        p = '0; p[0] = enc_i(6'd9, 5'd0, 5'd1, 16'd1); p[1] = enc_i(6'd5, 5'd1, 5'd0, 16'd2);
        p[2] = enc_i(6'd9, 5'd0, 5'd2, 16'd7); p[3] = enc_i(6'd9, 5'd2, 5'd2, 16'd100);
        p[4] = inc2; p[5] = jr0; p[6] = nop0;
        set_vec(10, "bne_taken_slot", 32'd8, 6, 0, 32'h0);

        p = '0; p[0] = enc_i(6'd9, 5'd0, 5'd1, 16'd4); p[1] = enc_i(6'd9, 5'd0, 5'd3, 16'd3);
        p[2] = enc_r(5'd1, 5'd3, 5'd2, 5'd0, 6'd4); p[3] = jr0; p[4] = nop0;
        set_vec(11, "sllv", 32'h0000_0030, 5, 0, 32'h0);

        // Reset state with reset held low
        cur_prog = vecs[0].prog;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_instr_address", instr_address, RV);
        check("rst_v0", register_v0, 32'h0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_strobes", {30'd0, data_read, data_write}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_active", {31'd0, active}, 32'd1);

        foreach (vecs[k]) begin
            cur_prog = vecs[k].prog;
            do_reset();
            run_to_halt(cyc, wr, wd);
            check({vecs[k].name, "_v0"}, register_v0, vecs[k].exp_v0);
            check({vecs[k].name, "_cycles"}, 32'(cyc), 32'(vecs[k].exp_cycles));
            check({vecs[k].name, "_halt_pc"}, instr_address, 32'h0);
            check({vecs[k].name, "_writes"}, 32'(wr), 32'(vecs[k].exp_writes));
            if (vecs[k].exp_writes > 0) check({vecs[k].name, "_wdata"}, wd, vecs[k].exp_wd);
        end

        // BGEZ delay slot fetch order, then the core must stay halted
        cur_prog = vecs[0].prog;
        exp_fetch = '{RV, RV + 32'h4, RV + 32'hC, RV + 32'h10, RV + 32'h14, 32'h0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fetch_order_%0d", i), instr_address, exp_fetch[i]);
            if (i < 5) step();
        end
        check("halt_v0", register_v0, 32'd2);
        step();
        step();
        check("halt_hold_pc", instr_address, 32'h0);
        check("halt_hold_active", {31'd0, active}, 32'd0);
        check("halt_hold_v0", register_v0, 32'd2);

        // clk_enable stall in the middle of the BLTZ program
        cur_prog = vecs[1].prog;
        do_reset();
        step(); step(); step();
        check("pre_stall_pc", instr_address, RV + 32'hC);
        check("pre_stall_v0", register_v0, 32'd2);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc_%0d", i), instr_address, RV + 32'hC);
            check($sformatf("stall_v0_%0d", i), register_v0, 32'd2);
        end
        clk_enable = 1'b1;
        run_to_halt(cyc, wr, wd);
        check("post_stall_v0", register_v0, 32'd3);
        check("post_stall_cycles", 32'(cyc), 32'd3);

        // Asynchronous reset mid-program, with a taken-branch target pending
        cur_prog = vecs[0].prog;
        do_reset();
        step(); step();
        check("pre_areset_v0", register_v0, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_pc", instr_address, RV);
        check("areset_v0", register_v0, 32'h0);
        check("areset_active", {31'd0, active}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_to_halt(cyc, wr, wd);
        check("after_areset_v0", register_v0, 32'd2);
        check("after_areset_cycles", 32'(cyc), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
